// File: rtl/eval_dma_calc_stream_writer.sv
// Write DMA: AXI4-Stream result beats to AXI4 INCR bursts, split at 4 KB pages.
// Bursts are queued as beat counts so W framing follows issued AWs exactly.
module eval_dma_calc_stream_writer #(
  parameter int ADDR_WIDTH      = 40,
  parameter int DATA_WIDTH      = 128,
  parameter int LEN_WIDTH       = 32,
  parameter int MAX_BURST       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    aresetn,
  input  logic                    aclk,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   start_addr,
  input  logic [LEN_WIDTH-1:0]    start_len,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  input  logic [DATA_WIDTH-1:0]   s_axi4s_tdata,
  input  logic                    s_axi4s_tvalid,
  output logic                    s_axi4s_tready,
  output logic [ADDR_WIDTH-1:0]   m_axi4_awaddr,
  output logic [7:0]              m_axi4_awlen,
  output logic [2:0]              m_axi4_awsize,
  output logic [1:0]              m_axi4_awburst,
  output logic                    m_axi4_awvalid,
  input  logic                    m_axi4_awready,
  output logic [DATA_WIDTH-1:0]   m_axi4_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi4_wstrb,
  output logic                    m_axi4_wlast,
  output logic                    m_axi4_wvalid,
  input  logic                    m_axi4_wready,
  input  logic [1:0]              m_axi4_bresp,
  input  logic                    m_axi4_bvalid,
  output logic                    m_axi4_bready
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SZ    = $clog2(BYTES);
  localparam int PW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OW    = $clog2(MAX_OUTSTANDING) + 1;
  localparam int PAGE  = 4096 >> SZ;
  localparam int PB    = $clog2(PAGE) + 1;

  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [OW-1:0]         outst;
  logic [OW-1:0]         fcnt;
  logic [8:0]            fifo [2**PW];
  logic [PW-1:0]         wp;
  logic [PW-1:0]         rp;
  logic [8:0]            beat;

  logic [PB-1:0] page_left;
  logic [31:0]   n_w;
  logic [8:0]    n_next;
  logic [8:0]    aw_n;
  logic          fifo_ne;
  logic          w_last;
  logic          aw_hs;
  logic          w_hs;
  logic          b_hs;
  logic          push;
  logic          pop;
  logic          can_issue;
  logic          fin;

  // beats left before the next 4 KB page
  assign page_left = PB'(PAGE) - PB'(addr[11:SZ]);

  always_comb begin
    n_w = 32'(MAX_BURST);
    if (32'(page_left) < n_w) n_w = 32'(page_left);
    if (32'(remaining) < n_w) n_w = 32'(remaining);
    n_next = n_w[8:0];
  end

  assign aw_n    = {1'b0, m_axi4_awlen} + 9'd1;
  assign fifo_ne = fcnt != '0;
  assign w_last  = fifo_ne && (beat == fifo[rp] - 9'd1);
  assign aw_hs   = m_axi4_awvalid && m_axi4_awready;
  assign w_hs    = m_axi4_wvalid && m_axi4_wready;
  assign b_hs    = m_axi4_bvalid;
  assign push    = aw_hs;
  assign pop     = w_hs && w_last;

  assign can_issue = busy && !m_axi4_awvalid
                  && remaining != '0
                  && outst < OW'(MAX_OUTSTANDING)
                  && fcnt < OW'(MAX_OUTSTANDING);

  assign fin = busy && remaining == '0 && !m_axi4_awvalid
            && fcnt == '0 && outst == '0;

  assign m_axi4_awsize  = 3'(SZ);
  assign m_axi4_awburst = 2'b01;
  assign m_axi4_wdata   = s_axi4s_tdata;
  assign m_axi4_wstrb   = '1;
  assign m_axi4_wlast   = w_last;
  assign m_axi4_wvalid  = s_axi4s_tvalid && fifo_ne;
  assign s_axi4s_tready = m_axi4_wready && fifo_ne;
  assign m_axi4_bready  = 1'b1;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      addr           <= '0;
      remaining      <= '0;
      outst          <= '0;
      fcnt           <= '0;
      wp             <= '0;
      rp             <= '0;
      beat           <= '0;
      m_axi4_awvalid <= 1'b0;
      m_axi4_awaddr  <= '0;
      m_axi4_awlen   <= '0;
      for (int i = 0; i < 2**PW; i++) fifo[i] <= '0;
    end else begin
      done <= 1'b0;
      if (b_hs && m_axi4_bresp != 2'b00) error <= 1'b1;
      if (start && !busy) begin
        busy      <= 1'b1;
        addr      <= {start_addr[ADDR_WIDTH-1:SZ], SZ'(0)};
        remaining <= start_len;
        error     <= 1'b0;
      end
      if (can_issue) begin
        m_axi4_awvalid <= 1'b1;
        m_axi4_awaddr  <= addr;
        m_axi4_awlen   <= 8'(n_next - 9'd1);
      end
      if (aw_hs) begin
        m_axi4_awvalid <= 1'b0;
        addr           <= addr + (ADDR_WIDTH'(aw_n) << SZ);
        remaining      <= remaining - LEN_WIDTH'(aw_n);
        fifo[wp]       <= aw_n;
        wp             <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      if (w_hs) beat <= w_last ? 9'd0 : beat + 9'd1;
      unique case (1'b1)
        push && !pop: fcnt <= fcnt + 1'b1;
        pop && !push: fcnt <= fcnt - 1'b1;
        default:      fcnt <= fcnt;
      endcase
      unique case (1'b1)
        aw_hs && !b_hs:             outst <= outst + 1'b1;
        b_hs && !aw_hs && outst != '0: outst <= outst - 1'b1;
        default:                    outst <= outst;
      endcase
      if (fin) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule
